// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline register: NZCV bit positions,
// writeback-select encodings and the EX control bundle.
package ex_mem_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       brtaken;
        logic       update_flags;
        logic [1:0] memtoreg;
    } ex_ctrl_t;

endpackage

// File: rtl/nzcv_reg.sv
// Architectural NZCV register with write enable and a same-cycle bypass so a
// conditional branch can see flags produced by the instruction still in EX.
module nzcv_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       fwd_sel,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic [3:0] q_fwd
);

    logic [3:0] flags_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else if (en) begin
            flags_q <= d;
        end
    end

    assign q     = flags_q;
    assign q_fwd = fwd_sel ? d : flags_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall/flush handling, NZCV state and a
// saturating count of bubbles loaded into MEM.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [4:0]        rd,
    input  logic              regwrite,
    input  logic              memwrite,
    input  logic              brtaken,
    input  logic              update_flags,
    input  logic [1:0]        memtoreg,
    input  logic [3:0]        alu_flags,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_ready,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [DATA_W-1:0] mem_branch_target,
    output logic [4:0]        mem_rd,
    output logic              mem_regwrite,
    output logic              mem_memwrite,
    output logic              mem_brtaken,
    output logic [1:0]        mem_memtoreg,
    output logic [3:0]        flags,
    output logic [3:0]        flags_fwd,
    output logic [CNT_W-1:0]  bubble_cnt
);

    ex_ctrl_t ctrl_in;
    logic     accept;
    logic     load_insn;
    logic     load_bubble;

    logic              valid_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] store_q;
    logic [DATA_W-1:0] target_q;
    logic [4:0]        rd_q;
    logic              regwrite_q;
    logic              memwrite_q;
    logic              brtaken_q;
    logic [1:0]        memtoreg_q;
    logic [CNT_W-1:0]  cnt_q;

    assign ctrl_in = '{regwrite: regwrite, memwrite: memwrite, brtaken: brtaken,
                       update_flags: update_flags, memtoreg: memtoreg};

    assign accept      = !stall && !flush;
    assign load_insn   = accept && ex_valid;
    // A stalled MEM holds even under flush: its instruction is older.
    assign load_bubble = !stall && (flush || !ex_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            alu_q      <= '0;
            store_q    <= '0;
            target_q   <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            brtaken_q  <= 1'b0;
            memtoreg_q <= WB_ALU;
        end else if (!stall) begin
            valid_q    <= load_insn;
            regwrite_q <= load_insn & ctrl_in.regwrite;
            memwrite_q <= load_insn & ctrl_in.memwrite;
            brtaken_q  <= load_insn & ctrl_in.brtaken;
            memtoreg_q <= load_insn ? ctrl_in.memtoreg : WB_ALU;
            if (accept) begin
                alu_q    <= alu_result;
                store_q  <= store_data;
                target_q <= branch_target;
                rd_q     <= rd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load_bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    nzcv_reg u_nzcv (
        .clk     (clk),
        .reset   (reset),
        .en      (load_insn && ctrl_in.update_flags),
        .fwd_sel (ex_valid && ctrl_in.update_flags),
        .d       (alu_flags),
        .q       (flags),
        .q_fwd   (flags_fwd)
    );

    assign ex_ready          = !stall;
    assign mem_valid         = valid_q;
    assign mem_alu_result    = alu_q;
    assign mem_store_data    = store_q;
    assign mem_branch_target = target_q;
    assign mem_rd            = rd_q;
    assign mem_regwrite      = regwrite_q;
    assign mem_memwrite      = memwrite_q;
    assign mem_brtaken       = brtaken_q;
    assign mem_memtoreg      = memtoreg_q;
    assign bubble_cnt        = cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage with hand-computed expectations.
module tb_ex_mem_stage;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] branch_target;
    logic [4:0]        rd;
    logic              regwrite;
    logic              memwrite;
    logic              brtaken;
    logic              update_flags;
    logic [1:0]        memtoreg;
    logic [3:0]        alu_flags;
    logic              stall;
    logic              flush;
    logic              ex_ready;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [DATA_W-1:0] mem_branch_target;
    logic [4:0]        mem_rd;
    logic              mem_regwrite;
    logic              mem_memwrite;
    logic              mem_brtaken;
    logic [1:0]        mem_memtoreg;
    logic [3:0]        flags;
    logic [3:0]        flags_fwd;
    logic [CNT_W-1:0]  bubble_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .alu_result        (alu_result),
        .store_data        (store_data),
        .branch_target     (branch_target),
        .rd                (rd),
        .regwrite          (regwrite),
        .memwrite          (memwrite),
        .brtaken           (brtaken),
        .update_flags      (update_flags),
        .memtoreg          (memtoreg),
        .alu_flags         (alu_flags),
        .stall             (stall),
        .flush             (flush),
        .ex_ready          (ex_ready),
        .mem_valid         (mem_valid),
        .mem_alu_result    (mem_alu_result),
        .mem_store_data    (mem_store_data),
        .mem_branch_target (mem_branch_target),
        .mem_rd            (mem_rd),
        .mem_regwrite      (mem_regwrite),
        .mem_memwrite      (mem_memwrite),
        .mem_brtaken       (mem_brtaken),
        .mem_memtoreg      (mem_memtoreg),
        .flags             (flags),
        .flags_fwd         (flags_fwd),
        .bubble_cnt        (bubble_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] alu, input logic [4:0] r,
                         input logic rw, input logic mw, input logic uf, input logic [3:0] f);
        ex_valid      = v;
        alu_result    = alu;
        store_data    = alu ^ 64'hAA;
        branch_target = alu + 64'h100;
        rd            = r;
        regwrite      = rw;
        memwrite      = mw;
        update_flags  = uf;
        alu_flags     = f;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        stall    = 1'b1;
        flush    = 1'b0;
        brtaken  = 1'b0;
        memtoreg = 2'b00;
        drive(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'h0);
        #3;
        check("rst_valid", 64'(mem_valid), 64'h0);
        check("rst_flags", 64'(flags), 64'h0);
        check("rst_cnt", 64'(bubble_cnt), 64'h0);
        check("rst_ready", 64'(ex_ready), 64'h0);
        #9 reset = 1'b1;
        step();

        // Basic accept
        stall    = 1'b0;
        memtoreg = 2'b01;
        drive(1'b1, 64'h10, 5'd3, 1'b1, 1'b0, 1'b0, 4'h0);
        #1 check("acc_ready", 64'(ex_ready), 64'h1);
        step();
        check("acc_alu", mem_alu_result, 64'h10);
        check("acc_rd", 64'(mem_rd), 64'd3);
        check("acc_rw", 64'(mem_regwrite), 64'h1);
        check("acc_valid", 64'(mem_valid), 64'h1);
        check("acc_sd", mem_store_data, 64'hBA);
        check("acc_bt", mem_branch_target, 64'h110);
        check("acc_m2r", 64'(mem_memtoreg), 64'h1);
        check("acc_cnt", 64'(bubble_cnt), 64'h0);

        // SUBS then ADD
        memtoreg = 2'b00;
        drive(1'b1, 64'h20, 5'd4, 1'b1, 1'b0, 1'b1, 4'b0100);
        #1;
        check("subs_fwd", 64'(flags_fwd), 64'h4);
        check("subs_flags_pre", 64'(flags), 64'h0);
        step();
        check("subs_flags", 64'(flags), 64'h4);
        drive(1'b1, 64'h28, 5'd5, 1'b1, 1'b0, 1'b0, 4'b1011);
        #1 check("add_fwd", 64'(flags_fwd), 64'h4);
        step();
        check("add_flags", 64'(flags), 64'h4);
        check("add_alu", mem_alu_result, 64'h28);

        // Three stalled cycles with changing EX inputs
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h30 + 64'(i), 5'(6 + i), 1'b0, 1'b1, 1'b1, 4'b1111);
            #1 check("stl_ready", 64'(ex_ready), 64'h0);
            step();
            check("stl_alu", mem_alu_result, 64'h28);
            check("stl_rd", 64'(mem_rd), 64'd5);
            check("stl_mw", 64'(mem_memwrite), 64'h0);
            check("stl_flags", 64'(flags), 64'h4);
        end
        stall = 1'b0;
        step();
        check("rel_alu", mem_alu_result, 64'h32);
        check("rel_rd", 64'(mem_rd), 64'd8);
        check("rel_mw", 64'(mem_memwrite), 64'h1);
        check("rel_flags", 64'(flags), 64'hF);

        // Flush
        flush = 1'b1;
        drive(1'b1, 64'h99, 5'd9, 1'b1, 1'b1, 1'b1, 4'b0001);
        step();
        check("fl_mw", 64'(mem_memwrite), 64'h0);
        check("fl_rw", 64'(mem_regwrite), 64'h0);
        check("fl_valid", 64'(mem_valid), 64'h0);
        check("fl_flags", 64'(flags), 64'hF);
        check("fl_alu", mem_alu_result, 64'h32);
        check("fl_cnt", 64'(bubble_cnt), 64'h1);

        // Stall and flush together
        flush = 1'b0;
        drive(1'b1, 64'h44, 5'd9, 1'b1, 1'b0, 1'b0, 4'h0);
        step();
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b1, 64'h55, 5'd10, 1'b0, 1'b1, 1'b1, 4'h2);
        step();
        check("sf_alu", mem_alu_result, 64'h44);
        check("sf_valid", 64'(mem_valid), 64'h1);
        check("sf_rw", 64'(mem_regwrite), 64'h1);
        check("sf_cnt", 64'(bubble_cnt), 64'h1);

        // Invalid EX accepted: controls forced low, payload captured
        stall   = 1'b0;
        flush   = 1'b0;
        brtaken = 1'b1;
        drive(1'b0, 64'h66, 5'd11, 1'b1, 1'b1, 1'b1, 4'h3);
        #1 check("inv_fwd", 64'(flags_fwd), 64'hF);
        step();
        check("inv_valid", 64'(mem_valid), 64'h0);
        check("inv_ctrl", {61'h0, mem_regwrite, mem_memwrite, mem_brtaken}, 64'h0);
        check("inv_alu", mem_alu_result, 64'h66);
        check("inv_flags", 64'(flags), 64'hF);
        check("inv_cnt", 64'(bubble_cnt), 64'h2);

        // Run the counter up to saturation
        for (int i = 0; i < 65532; i++) step();
        check("sat_pre", 64'(bubble_cnt), 64'hFFFE);
        for (int i = 0; i < 3; i++) step();
        check("sat_max", 64'(bubble_cnt), 64'hFFFF);
        step();
        check("sat_hold", 64'(bubble_cnt), 64'hFFFF);

        // Asynchronous reset while stalled
        stall = 1'b1;
        drive(1'b1, 64'h70, 5'd12, 1'b1, 1'b0, 1'b1, 4'h8);
        step();
        #2 reset = 1'b0;
        #1;
        check("ar_valid", 64'(mem_valid), 64'h0);
        check("ar_alu", mem_alu_result, 64'h0);
        check("ar_flags", 64'(flags), 64'h0);
        check("ar_cnt", 64'(bubble_cnt), 64'h0);
        check("ar_rd", 64'(mem_rd), 64'h0);
        step();
        reset   = 1'b1;
        stall   = 1'b0;
        brtaken = 1'b0;
        drive(1'b1, 64'h77, 5'd1, 1'b1, 1'b0, 1'b0, 4'h0);
        step();
        check("post_alu", mem_alu_result, 64'h77);
        check("post_valid", 64'(mem_valid), 64'h1);
        check("post_cnt", 64'(bubble_cnt), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
